mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester to one-server arbiter between the instruction cache and data cache miss ports (their hmem_if side) and the shared backing memory.
- Round-robin grant, locked per transaction until the server pulses fulfilled.
- Forwards one request at a time and routes the response back to the granted requester only.
- Top-level instantiation: icache.hmem_if -> port 0, dcache.hmem_if -> port 1, memory -> m_*.

Parameters:
- XLEN, 32, address and data width in bits
- P0_READ_ONLY, 1, port 0 never stores; p0_wdata/p0_op ignored and forced to LOAD downstream

Ports:
- clk  input  1  clock
- rst_if.reset  input  1  asynchronous active-high reset
- p0_valid  input  1  port 0 request valid, held until p0_fulfilled
- p0_op  input  1  0=LOAD, 1=STORE
- p0_size  input  2  0=byte, 1=half, 2=word
- p0_addr  input  XLEN  request address
- p0_wdata  input  XLEN  store data
- p0_rdata  output  XLEN  load data, valid with p0_fulfilled
- p0_fulfilled  output  1  one-cycle completion pulse
- p1_valid, p1_op, p1_size, p1_addr, p1_wdata, p1_rdata, p1_fulfilled  same as port 0
- m_valid  output  1  downstream request valid
- m_op  output  1  downstream op
- m_size  output  2  downstream size
- m_addr  output  XLEN  downstream address
- m_wdata  output  XLEN  downstream store data
- m_rdata  input  XLEN  downstream load data
- m_fulfilled  input  1  downstream completion pulse

Behaviour:
- State machine:
  - IDLE: if any pX_valid, grant a port per round-robin and go to BUSY.
  - BUSY: m_valid=1. On m_fulfilled, go to RELEASE.
  - RELEASE: one cycle, m_valid=0, then IDLE. This lets the requester drop valid so the same request is not re-granted.
- Round-robin:
  - Register last_grant, reset value 1, so port 0 wins the first tie.
  - If both ports are valid in IDLE, grant !last_grant; a single valid port wins regardless.
  - last_grant updates on entry to BUSY.
- Request latching:
  - op/size/addr/wdata of the granted port are latched into output registers on the IDLE->BUSY edge.
  - m_* hold stable through BUSY even if the requester's inputs change.
- Latency: request sampled at edge N; m_valid=1 from cycle N+1.
- Response path:
  - pX_fulfilled = m_fulfilled && state==BUSY && grant==X, combinational with zero added latency.
  - pX_rdata = m_rdata when granted, else 0.
  - The non-granted port never sees fulfilled.
- A requester deasserting valid during BUSY does not abort the transaction; the arbiter completes it and discards the response.
- m_fulfilled outside BUSY is ignored.
- Best-case throughput: one transaction per 3 cycles (IDLE, BUSY with same-cycle fulfilled, RELEASE).
- Reset, asynchronous, including mid-transaction:
  - state=IDLE, last_grant=1, grant=0.
  - m_valid=0; m_op, m_size, m_addr, m_wdata = 0.
  - pX_fulfilled=0, pX_rdata=0.
  - An in-flight downstream transaction is abandoned.

Optional Feature:
- Macro: MEM_ARBITER_PERF_EN
- Defined:
  - Adds outputs p0_wait_cycles and p1_wait_cycles, 32 bits each.
  - Each counts cycles where pX_valid=1 and that port is not granted, i.e. the port is in IDLE-pending, or another port is in BUSY/RELEASE.
  - Saturates at all-ones; cleared by reset.
- Undefined: the counter ports and logic are absent; functional behaviour is identical.

Test Plan:
- Single port 0 LOAD:
  - Stimulus: p0_valid=1, addr=0x100; memory returns 0xDEADBEEF with fulfilled 2 cycles after m_valid rises.
  - Required: m_valid=1 one cycle after request, m_addr=0x100, m_op=0; p0_fulfilled pulses once with p0_rdata=0xDEADBEEF; p1_fulfilled stays 0.
- Simultaneous requests after reset:
  - Stimulus: p0_valid and p1_valid both asserted, p1 STORE addr=0x200 wdata=0x12345678.
  - Required: port 0 served first; after RELEASE, port 1 is granted with m_op=1, m_addr=0x200, m_wdata=0x12345678.
- Fairness:
  - Stimulus: both ports continuously re-request for 6 transactions.
  - Required: grants alternate 0,1,0,1,0,1.
- Input change during BUSY:
  - Stimulus: after grant, p1_addr changes from 0x200 to 0x300.
  - Required: m_addr stays 0x200 until fulfilled.
- Reset mid-BUSY:
  - Stimulus: assert rst_if.reset while m_valid=1.
  - Required: m_valid drops in the same cycle; no pX_fulfilled; after release, a tied request goes to port 0.
- Stray fulfilled:
  - Stimulus: pulse m_fulfilled in IDLE.
  - Required: no pX_fulfilled, state unchanged.
  - With MEM_ARBITER_PERF_EN: during a 4-cycle port 0 transaction with p1_valid held, p1_wait_cycles increments by the exact stall count.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the two cache miss ports, the arbiter and
// the shared backing memory.
//   slave  : the arbiter's view (takes requests, drives memory side)
//   master : the surrounding system's view (caches + memory model)
// MEM_ARBITER_PERF_EN adds the per-port wait-cycle counters.
`timescale 1ns/1ps
interface mem_arbiter_if #(parameter int XLEN = 32);
   logic            p0_valid;
   logic            p0_op;
   logic [1:0]      p0_size;
   logic [XLEN-1:0] p0_addr;
   logic [XLEN-1:0] p0_wdata;
   logic [XLEN-1:0] p0_rdata;
   logic            p0_fulfilled;

   logic            p1_valid;
   logic            p1_op;
   logic [1:0]      p1_size;
   logic [XLEN-1:0] p1_addr;
   logic [XLEN-1:0] p1_wdata;
   logic [XLEN-1:0] p1_rdata;
   logic            p1_fulfilled;

   logic            m_valid;
   logic            m_op;
   logic [1:0]      m_size;
   logic [XLEN-1:0] m_addr;
   logic [XLEN-1:0] m_wdata;
   logic [XLEN-1:0] m_rdata;
   logic            m_fulfilled;

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0]     p0_wait_cycles;
   logic [31:0]     p1_wait_cycles;
`endif

   modport slave (
      input  p0_valid, p0_op, p0_size, p0_addr, p0_wdata,
      output p0_rdata, p0_fulfilled,
      input  p1_valid, p1_op, p1_size, p1_addr, p1_wdata,
      output p1_rdata, p1_fulfilled,
      output m_valid, m_op, m_size, m_addr, m_wdata,
      input  m_rdata, m_fulfilled
`ifdef MEM_ARBITER_PERF_EN
      , output p0_wait_cycles, p1_wait_cycles
`endif
   );

   modport master (
      output p0_valid, p0_op, p0_size, p0_addr, p0_wdata,
      input  p0_rdata, p0_fulfilled,
      output p1_valid, p1_op, p1_size, p1_addr, p1_wdata,
      input  p1_rdata, p1_fulfilled,
      input  m_valid, m_op, m_size, m_addr, m_wdata,
      output m_rdata, m_fulfilled
`ifdef MEM_ARBITER_PERF_EN
      , input p0_wait_cycles, p1_wait_cycles
`endif
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the shared backing memory.
// Port 0 = icache miss port, port 1 = dcache miss port. The grant is held
// for a whole transaction and followed by a one-cycle RELEASE gap so the
// requester can drop valid before the next arbitration.
// Optional: MEM_ARBITER_PERF_EN adds saturating per-port wait counters.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | no transaction; arbitrate pending requests
//   S_BUSY    | granted request presented on m_*; waiting for m_fulfilled
//   S_RELEASE | one idle cycle so the served requester can drop valid
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int XLEN         = 32,
   parameter bit P0_READ_ONLY = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   mem_arbiter_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_BUSY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_last_grant;
   logic            r_grant;
   logic            r_m_valid;
   logic            r_m_op;
   logic [1:0]      r_m_size;
   logic [XLEN-1:0] r_m_addr;
   logic [XLEN-1:0] r_m_wdata;

   logic            w_any;
   logic            w_pick;
   logic            w_p0_op;
   logic [XLEN-1:0] w_p0_wdata;
   logic            w_busy;

   assign w_any  = bus.p0_valid | bus.p1_valid;
   // On a tie the port that did not win last time goes next; otherwise the
   // lone requester wins.
   assign w_pick = (bus.p0_valid && bus.p1_valid) ? ~r_last_grant : bus.p1_valid;
   // The icache port never stores, so its op/wdata are not trusted.
   assign w_p0_op    = P0_READ_ONLY ? 1'b0 : bus.p0_op;
   assign w_p0_wdata = P0_READ_ONLY ? '0 : bus.p0_wdata;
   assign w_busy     = (r_state == S_BUSY);

   // Arbitration FSM with registered downstream request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_m_valid    <= 1'b0;
         r_m_op       <= 1'b0;
         r_m_size     <= 2'd0;
         r_m_addr     <= '0;
         r_m_wdata    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_state      <= S_BUSY;
                  r_grant      <= w_pick;
                  r_last_grant <= w_pick;
                  r_m_valid    <= 1'b1;
                  if (w_pick) begin
                     r_m_op    <= bus.p1_op;
                     r_m_size  <= bus.p1_size;
                     r_m_addr  <= bus.p1_addr;
                     r_m_wdata <= bus.p1_wdata;
                  end else begin
                     r_m_op    <= w_p0_op;
                     r_m_size  <= bus.p0_size;
                     r_m_addr  <= bus.p0_addr;
                     r_m_wdata <= w_p0_wdata;
                  end
               end
            end
            S_BUSY: begin
               if (bus.m_fulfilled) begin
                  r_state   <= S_RELEASE;
                  r_m_valid <= 1'b0;
               end
            end
            S_RELEASE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state   <= S_IDLE;
               r_m_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.m_valid = r_m_valid;
   assign bus.m_op    = r_m_op;
   assign bus.m_size  = r_m_size;
   assign bus.m_addr  = r_m_addr;
   assign bus.m_wdata = r_m_wdata;

   // Responses are steered only while a transaction is actually in flight.
   assign bus.p0_fulfilled = bus.m_fulfilled && w_busy && (r_grant == 1'b0);
   assign bus.p1_fulfilled = bus.m_fulfilled && w_busy && (r_grant == 1'b1);
   assign bus.p0_rdata     = (w_busy && (r_grant == 1'b0)) ? bus.m_rdata : '0;
   assign bus.p1_rdata     = (w_busy && (r_grant == 1'b1)) ? bus.m_rdata : '0;

`ifdef MEM_ARBITER_PERF_EN
   logic [31:0] r_p0_wait;
   logic [31:0] r_p1_wait;
   logic        w_p0_wait;
   logic        w_p1_wait;

   // A port is stalled while pending in IDLE or while the other port owns
   // the memory (BUSY or RELEASE).
   assign w_p0_wait = bus.p0_valid && ((r_state == S_IDLE) || (r_grant != 1'b0));
   assign w_p1_wait = bus.p1_valid && ((r_state == S_IDLE) || (r_grant != 1'b1));

   // Saturating stall counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p0_wait <= '0;
         r_p1_wait <= '0;
      end else begin
         if (w_p0_wait && (r_p0_wait != '1)) r_p0_wait <= r_p0_wait + 32'd1;
         if (w_p1_wait && (r_p1_wait != '1)) r_p1_wait <= r_p1_wait + 32'd1;
      end
   end

   assign bus.p0_wait_cycles = r_p0_wait;
   assign bus.p1_wait_cycles = r_p1_wait;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected downstream requests are queued
// as each requester is driven and checked as the arbiter presents them.
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.XLEN(32)) bus ();

   mem_arbiter #(.XLEN(32), .P0_READ_ONLY(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      bit          port;
      logic        op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit port, input logic op, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
      exp_t e;
      e.port = port; e.op = op; e.size = size; e.addr = addr; e.wdata = wdata;
      sb.push_back(e);
   endtask

   // Acts as the memory: waits for the next request, checks it against the
   // scoreboard, answers after 'delay' BUSY cycles and checks the routing.
   task automatic serve(input int delay, input logic [31:0] rd, input bit drop, input bit mutate);
      exp_t e;
      bit   seen;
      if (sb.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
         return;
      end
      e = sb.pop_front();
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (bus.m_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!seen) begin
         chk("m_valid_timeout", 32'd0, 32'd1);
         return;
      end
      chk("m_op",    32'(bus.m_op),   32'(e.op));
      chk("m_size",  32'(bus.m_size), 32'(e.size));
      chk("m_addr",  bus.m_addr,      e.addr);
      chk("m_wdata", bus.m_wdata,     e.wdata);
      for (int k = 0; k < delay; k++) begin
         if (mutate && k == 0) bus.p1_addr = 32'h300;
         @(negedge clk);
         chk("m_addr_hold",  bus.m_addr,          e.addr);
         chk("m_valid_hold", 32'(bus.m_valid),    32'd1);
      end
      bus.m_rdata     = rd;
      bus.m_fulfilled = 1'b1;
      #1;
      chk("fulfilled_granted", 32'(e.port ? bus.p1_fulfilled : bus.p0_fulfilled), 32'd1);
      chk("fulfilled_other",   32'(e.port ? bus.p0_fulfilled : bus.p1_fulfilled), 32'd0);
      chk("rdata_granted",     e.port ? bus.p1_rdata : bus.p0_rdata, rd);
      chk("rdata_other",       e.port ? bus.p0_rdata : bus.p1_rdata, 32'd0);
      @(negedge clk);
      bus.m_fulfilled = 1'b0;
      bus.m_rdata     = 32'hA5A5_0000;
      #1;
      chk("release_m_valid",   32'(bus.m_valid), 32'd0);
      chk("release_fulfilled", 32'({bus.p0_fulfilled, bus.p1_fulfilled}), 32'd0);
      chk("release_rdata",     bus.p0_rdata | bus.p1_rdata, 32'd0);
      if (drop) begin
         if (e.port) bus.p1_valid = 1'b0;
         else        bus.p0_valid = 1'b0;
      end
   endtask

   initial begin
      bit seen;
`ifdef MEM_ARBITER_PERF_EN
      logic [31:0] c0;
      logic [31:0] c1;
`endif
      bus.p0_valid = 1'b0; bus.p0_op = 1'b0; bus.p0_size = 2'd0;
      bus.p0_addr  = '0;   bus.p0_wdata = '0;
      bus.p1_valid = 1'b0; bus.p1_op = 1'b0; bus.p1_size = 2'd0;
      bus.p1_addr  = '0;   bus.p1_wdata = '0;
      bus.m_rdata  = 32'hCAFE_0000;
      bus.m_fulfilled = 1'b1;

      // Reset state, with a junk response on the memory side.
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_m_valid",   32'(bus.m_valid), 32'd0);
      chk("rst_m_op",      32'(bus.m_op),    32'd0);
      chk("rst_m_size",    32'(bus.m_size),  32'd0);
      chk("rst_m_addr",    bus.m_addr,       32'd0);
      chk("rst_m_wdata",   bus.m_wdata,      32'd0);
      chk("rst_fulfilled", 32'({bus.p0_fulfilled, bus.p1_fulfilled}), 32'd0);
      chk("rst_p0_rdata",  bus.p0_rdata,     32'd0);
      chk("rst_p1_rdata",  bus.p1_rdata,     32'd0);
      rst = 1'b0;
      bus.m_fulfilled = 1'b0;
      @(negedge clk);

      // Single port 0 LOAD.
      bus.p0_valid = 1'b1; bus.p0_addr = 32'h100; bus.p0_size = 2'd2; bus.p0_op = 1'b0;
      push(1'b0, 1'b0, 2'd2, 32'h100, 32'h0);
      #1;
      chk("t1_m_valid_before", 32'(bus.m_valid), 32'd0);
      @(negedge clk);
      chk("t1_latency", 32'(bus.m_valid), 32'd1);
      serve(2, 32'hDEAD_BEEF, 1'b1, 1'b0);
      @(negedge clk);
      chk("t1_no_second_pulse", 32'(bus.p0_fulfilled), 32'd0);
      chk("t1_idle", 32'(bus.m_valid), 32'd0);

      // Simultaneous requests after reset; port 0 op/wdata must be ignored.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.p0_valid = 1'b1; bus.p0_op = 1'b1; bus.p0_wdata = 32'hFFFF_FFFF;
      bus.p0_addr  = 32'h140; bus.p0_size = 2'd1;
      bus.p1_valid = 1'b1; bus.p1_op = 1'b1; bus.p1_size = 2'd2;
      bus.p1_addr  = 32'h200; bus.p1_wdata = 32'h1234_5678;
      push(1'b0, 1'b0, 2'd1, 32'h140, 32'h0);
      push(1'b1, 1'b1, 2'd2, 32'h200, 32'h1234_5678);
      serve(1, 32'h1111_0000, 1'b1, 1'b0);
      // p1_addr changes to 0x300 during BUSY; m_addr must hold 0x200.
      serve(2, 32'h2222_0000, 1'b1, 1'b1);

      // Fairness: both ports keep requesting for six transactions.
      @(negedge clk);
      bus.p0_op = 1'b0; bus.p0_size = 2'd2; bus.p0_addr = 32'h400;
      bus.p1_op = 1'b1; bus.p1_size = 2'd2; bus.p1_addr = 32'h500; bus.p1_wdata = 32'h55AA_55AA;
      bus.p0_valid = 1'b1; bus.p1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0) push(1'b0, 1'b0, 2'd2, 32'h400, 32'h0);
         else            push(1'b1, 1'b1, 2'd2, 32'h500, 32'h55AA_55AA);
      end
      for (int i = 0; i < 6; i++) begin
         serve(i % 3, 32'h3000 + 32'(i), (i == 5), 1'b0);
      end
      bus.p0_valid = 1'b0;

      // Stray fulfilled in IDLE.
      @(negedge clk);
      @(negedge clk);
      bus.m_rdata = 32'h77; bus.m_fulfilled = 1'b1;
      #1;
      chk("stray_fulfilled", 32'({bus.p0_fulfilled, bus.p1_fulfilled}), 32'd0);
      chk("stray_rdata",     bus.p0_rdata | bus.p1_rdata, 32'd0);
      @(negedge clk);
      bus.m_fulfilled = 1'b0;
      chk("stray_m_valid", 32'(bus.m_valid), 32'd0);
      bus.p1_valid = 1'b1; bus.p1_addr = 32'h300;
      push(1'b1, 1'b1, 2'd2, 32'h300, 32'h55AA_55AA);
      serve(0, 32'h4444, 1'b1, 1'b0);

`ifdef MEM_ARBITER_PERF_EN
      // Port 0 transaction of 4 cycles (IDLE, BUSY, BUSY, RELEASE) with p1 held.
      @(negedge clk);
      @(negedge clk);
      c0 = bus.p0_wait_cycles;
      c1 = bus.p1_wait_cycles;
      bus.p0_valid = 1'b1; bus.p0_addr = 32'h600; bus.p0_size = 2'd2;
      bus.p1_valid = 1'b1; bus.p1_addr = 32'h700; bus.p1_op = 1'b0;
      bus.p1_size  = 2'd0; bus.p1_wdata = 32'h0;
      push(1'b0, 1'b0, 2'd2, 32'h600, 32'h0);
      push(1'b1, 1'b0, 2'd0, 32'h700, 32'h0);
      serve(1, 32'h6666, 1'b1, 1'b0);
      @(negedge clk);
      chk("perf_p1_wait", bus.p1_wait_cycles - c1, 32'd4);
      chk("perf_p0_wait", bus.p0_wait_cycles - c0, 32'd1);
      serve(0, 32'h7777, 1'b1, 1'b0);
`endif

      // Reset while BUSY with port 0 (last_grant becomes 0 before reset).
      @(negedge clk);
      @(negedge clk);
      bus.p0_valid = 1'b1; bus.p0_addr = 32'h800; bus.p0_size = 2'd2; bus.p0_op = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.m_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rb_busy_seen", 32'(seen), 32'd1);
      bus.m_rdata = 32'h88; bus.m_fulfilled = 1'b1;
      rst = 1'b1;
      #1;
      chk("rb_m_valid",   32'(bus.m_valid), 32'd0);
      chk("rb_fulfilled", 32'({bus.p0_fulfilled, bus.p1_fulfilled}), 32'd0);
      chk("rb_m_addr",    bus.m_addr, 32'd0);
      chk("rb_p0_rdata",  bus.p0_rdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      bus.m_fulfilled = 1'b0;
      bus.p1_valid = 1'b1; bus.p1_addr = 32'h900; bus.p1_op = 1'b1;
      bus.p1_size  = 2'd2; bus.p1_wdata = 32'h99;
      push(1'b0, 1'b0, 2'd2, 32'h800, 32'h0);
      push(1'b1, 1'b1, 2'd2, 32'h900, 32'h99);
      serve(1, 32'hAB, 1'b1, 1'b0);
      serve(0, 32'hCD, 1'b1, 1'b0);

      @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
